// File: rtl/motor_pkg.sv
// Shared types and lookup functions for the six-step BLDC commutation controller.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int GATE_AH = 5;
  localparam int GATE_AL = 4;
  localparam int GATE_BH = 3;
  localparam int GATE_BL = 2;
  localparam int GATE_CH = 1;
  localparam int GATE_CL = 0;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } sector_t;

  function automatic sector_t hall_to_sector(input logic [2:0] hall);
    sector_t r;
    r.valid  = 1'b1;
    r.sector = 3'd0;
    case (hall)
      3'b101:  r.sector = 3'd0;
      3'b100:  r.sector = 3'd1;
      3'b110:  r.sector = 3'd2;
      3'b010:  r.sector = 3'd3;
      3'b011:  r.sector = 3'd4;
      3'b001:  r.sector = 3'd5;
      default: r.valid  = 1'b0;
    endcase
    return r;
  endfunction

  // Reverse rotation drives the step half a revolution ahead of the sector.
  function automatic logic [2:0] drive_step(input logic [2:0] sector, input logic reverse);
    if (!reverse)
      return sector;
    return (sector >= 3'd3) ? 3'(sector - 3'd3) : 3'(sector + 3'd3);
  endfunction

  function automatic logic [5:0] commutation_mask(input logic [2:0] step, input logic pwm_on);
    logic [5:0] m;
    m = '0;
    case (step)
      3'd0: begin m[GATE_AH] = pwm_on; m[GATE_BL] = 1'b1; end
      3'd1: begin m[GATE_AH] = pwm_on; m[GATE_CL] = 1'b1; end
      3'd2: begin m[GATE_BH] = pwm_on; m[GATE_CL] = 1'b1; end
      3'd3: begin m[GATE_BH] = pwm_on; m[GATE_AL] = 1'b1; end
      3'd4: begin m[GATE_CH] = pwm_on; m[GATE_AL] = 1'b1; end
      3'd5: begin m[GATE_CH] = pwm_on; m[GATE_BL] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser on the raw hall pins followed by a run-length debouncer;
// the output follows the synced value once it has been stable for DEBOUNCE_CYC cycles.
module hall_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_raw,
  output logic [2:0] hall_db
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [2:0]    sync1, sync2, cand;
  logic [CW-1:0] run_len, run_next;

  // run_next is the number of cycles sync2 will have held its current value.
  always_comb begin
    run_next = CW'(1);
    if (sync2 == cand)
      run_next = (run_len == CW'(DEBOUNCE_CYC)) ? run_len : run_len + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      run_len <= '0;
      hall_db <= '0;
    end else begin
      sync1   <= hall_raw;
      sync2   <= sync1;
      cand    <= sync2;
      run_len <= run_next;
      if (run_next == CW'(DEBOUNCE_CYC))
        hall_db <= sync2;
    end
  end

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation: hall decode, PWM high side, dead time on step changes,
// invalid-hall and stall fault latching, and hall-period measurement.
module bldc_commutation_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_BITS     = 9,
  parameter int DEADTIME_CYC = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int STALL_BITS   = 20
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  enable,
  input  logic                  direction,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic [2:0]            hall,
  input  logic                  fault_clear,
  output logic [5:0]            gates,
  output logic                  fault,
  output logic                  commutate,
  output logic [STALL_BITS-1:0] hall_period,
  output logic [1:0]            state
);

  localparam int DCW = $clog2(DEADTIME_CYC) + 1;

  state_t                st;
  logic [2:0]            hall_db, hall_prev;
  sector_t               sec, sec_prev;
  logic [2:0]            step, cur_step;
  logic                  step_chg, sector_chg;
  logic [PWM_BITS-1:0]   pwm_cnt, duty_lat;
  logic                  pwm_on;
  logic [STALL_BITS-1:0] stall_cnt;
  logic                  stall_sat;
  logic [DCW-1:0]        dead_cnt;

  hall_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_hall_debounce (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .hall_raw (hall),
    .hall_db  (hall_db)
  );

  assign state = st;

  always_comb begin
    sec        = hall_to_sector(hall_db);
    sec_prev   = hall_to_sector(hall_prev);
    step       = drive_step(sec.sector, direction);
    step_chg   = sec.valid && (step != cur_step);
    sector_chg = sec.valid && sec_prev.valid && (sec.sector != sec_prev.sector);
    pwm_on     = (pwm_cnt < duty_lat);
    stall_sat  = &stall_cnt;
  end

  // PWM timebase, step tracking and hall-period / stall counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt     <= '0;
      duty_lat    <= '0;
      hall_prev   <= '0;
      cur_step    <= '0;
      stall_cnt   <= '0;
      hall_period <= '0;
      commutate   <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (&pwm_cnt)
        duty_lat <= duty;
      hall_prev <= hall_db;
      if (sec.valid)
        cur_step <= step;
      commutate <= sector_chg;
      if (st == IDLE) begin
        stall_cnt <= '0;
      end else if (sector_chg) begin
        // Report elapsed cycles inclusive of the change edge, saturating.
        hall_period <= stall_sat ? stall_cnt : stall_cnt + 1'b1;
        stall_cnt   <= '0;
      end else if (!stall_sat) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st       <= IDLE;
      gates    <= '0;
      fault    <= 1'b0;
      dead_cnt <= '0;
    end else begin
      gates <= '0;
      if (st == FAULT) begin
        fault <= 1'b1;
        if (fault_clear && !enable) begin
          st    <= IDLE;
          fault <= 1'b0;
        end
      end else if (!enable) begin
        st <= IDLE;
      end else if (!sec.valid || (stall_sat && st != IDLE && duty_lat != '0)) begin
        st    <= FAULT;
        fault <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            st       <= DEAD;
            dead_cnt <= '0;
          end
          DEAD: begin
            if (step_chg) begin
              dead_cnt <= '0;
            end else if (dead_cnt == DCW'(DEADTIME_CYC - 1)) begin
              st    <= RUN;
              gates <= commutation_mask(step, pwm_on);
            end else begin
              dead_cnt <= dead_cnt + 1'b1;
            end
          end
          RUN: begin
            if (step_chg) begin
              st       <= DEAD;
              dead_cnt <= '0;
            end else begin
              gates <= commutation_mask(step, pwm_on);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assert property (@(posedge CLK) disable iff (!RESET_N)
    !(gates[GATE_AH] && gates[GATE_AL]) && !(gates[GATE_BH] && gates[GATE_BL]) &&
    !(gates[GATE_CH] && gates[GATE_CL]) &&
    $onehot0({gates[GATE_AH], gates[GATE_BH], gates[GATE_CH]}) &&
    $onehot0({gates[GATE_AL], gates[GATE_BL], gates[GATE_CL]}));

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Directed bench: table-driven six-step walk plus hand-written glitch, duty, direction,
// fault, stall and reset sequences; a second instance with an 8-bit stall counter.
module tb_bldc_commutation_ctrl;

  typedef struct {
    logic [2:0] hall;
    logic [5:0] hi;
    logic [5:0] lo;
  } vec_t;

  localparam logic [5:0] HI_MASK = 6'b101010;
  localparam logic [5:0] LO_MASK = 6'b010101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, direction, fault_clear;
  logic [8:0]  duty;
  logic [2:0]  hall;
  logic [5:0]  gates;
  logic        fault, commutate;
  logic [19:0] hall_period;
  logic [1:0]  state;

  logic        s_en, s_fc, s_comm, s_fault;
  logic [8:0]  s_duty;
  logic [2:0]  s_hall;
  logic [5:0]  s_gates;
  logic [7:0]  s_period;
  logic [1:0]  s_state;

  bldc_commutation_ctrl u_dut (
    .CLK (clk), .RESET_N (rst_n), .enable (enable), .direction (direction),
    .duty (duty), .hall (hall), .fault_clear (fault_clear), .gates (gates),
    .fault (fault), .commutate (commutate), .hall_period (hall_period), .state (state)
  );

  bldc_commutation_ctrl #(.STALL_BITS(8)) u_stall (
    .CLK (clk), .RESET_N (rst_n), .enable (s_en), .direction (1'b0),
    .duty (s_duty), .hall (s_hall), .fault_clear (s_fc), .gates (s_gates),
    .fault (s_fault), .commutate (s_comm), .hall_period (s_period), .state (s_state)
  );

  int   n_pass = 0;
  int   n_total = 0;
  vec_t vt[7];
  int   zeros, first_zero, exp_first, bad, on_cnt, comm_cnt, on1, on2, fault_k;
  logic found, prev_ah;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{3'b101, 6'b100000, 6'b000100};
    vt[1] = '{3'b100, 6'b100000, 6'b000001};
    vt[2] = '{3'b110, 6'b001000, 6'b000001};
    vt[3] = '{3'b010, 6'b001000, 6'b010000};
    vt[4] = '{3'b011, 6'b000010, 6'b010000};
    vt[5] = '{3'b001, 6'b000010, 6'b000100};
    vt[6] = '{3'b101, 6'b100000, 6'b000100};

    rst_n = 1'b0; enable = 1'b0; direction = 1'b0; fault_clear = 1'b0;
    duty = 9'd256; hall = 3'b101;
    s_en = 1'b0; s_fc = 1'b0; s_duty = 9'd100; s_hall = 3'b101;
    tick(3);
    check("reset_gates", gates, 0);
    check("reset_fault", fault, 0);
    check("reset_commutate", commutate, 0);
    check("reset_hall_period", hall_period, 0);
    check("reset_state", state, 0);
    rst_n = 1'b1;

    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (gates != 0 || state != 0 || fault != 0) bad++;
    end
    check("idle_100_cycles_bad", bad, 0);

    comm_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) enable = 1'b1;
      else hall = vt[i].hall;
      exp_first = (i == 0) ? 1 : 7;
      zeros = 0; first_zero = 0; bad = 0; on_cnt = 0;
      for (int k = 1; k <= 2000; k++) begin
        tick(1);
        if (commutate) comm_cnt++;
        if (k <= 20 && gates == 0) begin
          zeros++;
          if (first_zero == 0) first_zero = k;
        end
        if (k >= exp_first + 8) begin
          if ((gates & LO_MASK) != vt[i].lo) bad++;
          if ((gates & HI_MASK) != 0 && (gates & HI_MASK) != vt[i].hi) bad++;
        end
        if (k > 1000 && k <= 1512 && (gates & vt[i].hi) != 0) on_cnt++;
      end
      check($sformatf("step%0d_dead_cycles", i), zeros, 8);
      check($sformatf("step%0d_first_zero", i), first_zero, exp_first);
      check($sformatf("step%0d_gate_pattern_bad", i), bad, 0);
      check($sformatf("step%0d_high_on_per_512", i), on_cnt, 256);
      if (i >= 2) check($sformatf("step%0d_hall_period", i), hall_period, 2000);
    end
    check("commutate_pulses", comm_cnt, 6);

    comm_cnt = 0; bad = 0;
    hall = 3'b100;
    tick(2);
    hall = 3'b101;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (commutate) comm_cnt++;
      if ((gates & LO_MASK) != 6'b000100) bad++;
    end
    check("glitch_commutate", comm_cnt, 0);
    check("glitch_gates_bad", bad, 0);

    duty = 9'd100;
    tick(1100);
    found = 1'b0; prev_ah = gates[5];
    for (int k = 0; k < 1100 && !found; k++) begin
      tick(1);
      if (gates[5] && !prev_ah) found = 1'b1;
      else prev_ah = gates[5];
    end
    check("pwm_sync_found", found, 1);
    on1 = 1;
    for (int j = 1; j < 512; j++) begin
      tick(1);
      if (gates[5]) on1++;
      if (j == 200) duty = 9'd400;
    end
    on2 = 0;
    for (int j = 0; j < 512; j++) begin
      tick(1);
      if (gates[5]) on2++;
    end
    check("duty_old_period_on", on1, 100);
    check("duty_new_period_on", on2, 400);

    direction = 1'b1;
    tick(30);
    check("reverse_state_run", state, 2);
    bad = 0; on_cnt = 0; comm_cnt = 0;
    for (int k = 0; k < 512; k++) begin
      tick(1);
      if (commutate) comm_cnt++;
      if ((gates & LO_MASK) != 6'b010000) bad++;
      if ((gates & HI_MASK) != 0 && (gates & HI_MASK) != 6'b001000) bad++;
      if (gates[3]) on_cnt++;
    end
    check("reverse_step3_bad", bad, 0);
    check("reverse_bh_on", on_cnt, 400);
    check("reverse_commutate", comm_cnt, 0);

    hall = 3'b111;
    tick(10);
    check("invalid_state", state, 3);
    check("invalid_fault", fault, 1);
    check("invalid_gates", gates, 0);
    hall = 3'b101;
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    tick(3);
    check("clear_enabled_state", state, 3);
    check("clear_enabled_fault", fault, 1);
    enable = 1'b0; tick(1);
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    tick(1);
    check("clear_disabled_state", state, 0);
    check("clear_disabled_fault", fault, 0);

    s_en = 1'b1;
    fault_k = 0;
    for (int k = 1; k <= 400 && fault_k == 0; k++) begin
      tick(1);
      if (s_fault) fault_k = k;
    end
    check("stall_fault_window", (fault_k >= 250 && fault_k <= 262), 1);
    check("stall_state", s_state, 3);
    s_en = 1'b0; tick(1);
    s_fc = 1'b1; tick(1); s_fc = 1'b0;
    s_duty = 9'd0;
    tick(600);
    check("stall_cleared_state", s_state, 0);
    s_en = 1'b1;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      tick(1);
      if (s_fault) bad++;
    end
    check("stall_duty0_no_fault", bad, 0);
    check("stall_duty0_state_run", s_state, 2);

    enable = 1'b1;
    tick(30);
    check("prereset_state_run", state, 2);
    rst_n = 1'b0;
    #1;
    check("async_reset_gates", gates, 0);
    check("async_reset_state", state, 0);
    check("async_reset_hall_period", hall_period, 0);
    check("async_reset_stall_state", s_state, 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
